// File: rtl/trigger_sequencer.sv
// -----------------------------------------------------------------------------
// trigger_sequencer
//
// Multi-stage trigger on the logic analyser sample path. Sits between the
// sampler and the capture buffer as a single register stage (latency 1). Each
// output sample carries an event tag: [0] = trigger fired on this sample,
// [1] = sequence advanced to the next stage on this sample.
//
// TSN stages are evaluated in order. Each stage has a masked value compare, an
// invert option and a consecutive-match count. Stage configuration comes in over
// a write-only bus. Arm/abort pulses control the sequence.
//
// Stream handshake: a transfer happens on a port in any cycle where its
// tvalid and tready are both high; tvalid never depends on tready, and the
// input side is ready whenever the output register is empty or being drained.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   bus_wready            always 1
//   bus_wvalid            config write strobe
//   bus_waddr             [BAW-1:2] stage index, [1:0] 0 mask / 1 value / 2 cfg
//   bus_wdata             cfg word: [TCW-1:0] count, [TCW] invert, [TCW+1] final
//   ctl_arm, ctl_abort    control pulses (abort wins)
//   sts_state             0 IDLE, 1 ARMED, 2 FIRED (registered)
//   sts_stage             current stage index (registered)
//   sti_*                 input sample stream
//   sto_*                 output sample stream with event tags
// -----------------------------------------------------------------------------
module trigger_sequencer #(
  parameter int BAW = 6,
  parameter int BDW = 32,
  parameter int SDW = 32,
  parameter int SEW = 2,
  parameter int TSN = 4,
  parameter int TCW = 16,
  parameter int STW = (TSN > 1) ? $clog2(TSN) : 1
) (
  input  logic           clk,
  input  logic           rst,
  output logic           bus_wready,
  input  logic           bus_wvalid,
  input  logic [BAW-1:0] bus_waddr,
  input  logic [BDW-1:0] bus_wdata,
  input  logic           ctl_arm,
  input  logic           ctl_abort,
  output logic [1:0]     sts_state,
  output logic [STW-1:0] sts_stage,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic [SEW-1:0] sto_tevent,
  output logic [SDW-1:0] sto_tdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_e;

  // Stage configuration registers
  logic [SDW-1:0] mask_q  [TSN];
  logic [SDW-1:0] value_q [TSN];
  logic [TCW-1:0] count_q [TSN];
  logic           inv_q   [TSN];
  logic           fin_q   [TSN];

  // Sequencer and output stream registers
  state_e         state_q;
  logic [STW-1:0] stage_q;
  logic [TCW-1:0] cnt_q;

  // Combinational helpers
  logic           in_xfer;
  logic [BAW-3:0] wr_stage;
  logic [SDW-1:0] cur_mask;
  logic [SDW-1:0] cur_value;
  logic [TCW-1:0] cur_count;
  logic           cur_inv;
  logic           cur_fin;
  logic [TCW-1:0] cnt_tgt;
  logic [TCW:0]   cnt_p1;
  logic [TCW-1:0] cnt_inc_d;
  logic           hit;
  logic           sat;
  logic           last_stage;
  logic           eval;
  logic [SEW-1:0] ev_d;

  assign bus_wready = 1'b1;
  assign sti_tready = sto_tready | ~sto_tvalid;
  assign in_xfer    = sti_tvalid & sti_tready;
  assign wr_stage   = bus_waddr[BAW-1:2];

  assign sts_state  = state_q;
  assign sts_stage  = stage_q;

  assign cur_mask   = mask_q[stage_q];
  assign cur_value  = value_q[stage_q];
  assign cur_count  = count_q[stage_q];
  assign cur_inv    = inv_q[stage_q];
  assign cur_fin    = fin_q[stage_q];

  // A programmed count of zero behaves like one: a single hit satisfies.
  assign cnt_tgt    = (cur_count == '0) ? TCW'(1) : cur_count;
  // Compare one bit wider so cnt_q+1 cannot wrap into a false match.
  assign cnt_p1     = {1'b0, cnt_q} + {{TCW{1'b0}}, 1'b1};
  assign cnt_inc_d  = (cnt_q == '1) ? cnt_q : cnt_p1[TCW-1:0];

  assign hit        = ((((sti_tdata ^ cur_value) & cur_mask) == '0) ^ cur_inv);
  assign sat        = hit & (cnt_p1 == {1'b0, cnt_tgt});
  assign last_stage = (stage_q == STW'(TSN - 1));

  // Matching only counts on a real input transfer while ARMED; a control
  // pulse in the same cycle takes priority and discards the match.
  assign eval       = in_xfer & (state_q == ST_ARMED) & ~ctl_arm & ~ctl_abort;

  always_comb begin
    ev_d = '0;
    if (eval && sat) begin
      if (cur_fin || last_stage) ev_d[0] = 1'b1;
      else                       ev_d[1] = 1'b1;
    end
  end

  // Configuration writes. Reserved register 3 and out-of-range stages are
  // dropped rather than aliased onto existing stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < TSN; s++) begin
        mask_q[s]  <= '0;
        value_q[s] <= '0;
        count_q[s] <= '0;
        inv_q[s]   <= 1'b0;
        fin_q[s]   <= 1'b0;
      end
    end else if (bus_wvalid) begin
      for (int s = 0; s < TSN; s++) begin
        if (wr_stage == (BAW-2)'(s)) begin
          case (bus_waddr[1:0])
            2'd0: mask_q[s]  <= bus_wdata[SDW-1:0];
            2'd1: value_q[s] <= bus_wdata[SDW-1:0];
            2'd2: begin
              count_q[s] <= bus_wdata[TCW-1:0];
              inv_q[s]   <= bus_wdata[TCW];
              fin_q[s]   <= bus_wdata[TCW+1];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Sequencer FSM plus the output register of the stream stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      stage_q    <= '0;
      cnt_q      <= '0;
      sto_tvalid <= 1'b0;
      sto_tevent <= '0;
      sto_tdata  <= '0;
    end else begin
      if (in_xfer) begin
        sto_tvalid <= 1'b1;
        sto_tdata  <= sti_tdata;
        sto_tevent <= ev_d;
      end else if (sto_tready) begin
        sto_tvalid <= 1'b0;
      end

      if (ctl_abort) begin
        state_q <= ST_IDLE;
        stage_q <= '0;
        cnt_q   <= '0;
      end else if (ctl_arm) begin
        state_q <= ST_ARMED;
        stage_q <= '0;
        cnt_q   <= '0;
      end else if (eval) begin
        if (sat) begin
          cnt_q <= '0;
          if (cur_fin || last_stage) state_q <= ST_FIRED;
          else                       stage_q <= stage_q + STW'(1);
        end else if (hit) begin
          cnt_q <= cnt_inc_d;
        end else begin
          cnt_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_trigger_sequencer.sv
// -----------------------------------------------------------------------------
// tb_trigger_sequencer
//
// Directed bench for trigger_sequencer. Inputs change 1 ns after the rising
// edge and outputs are sampled there as well, well away from the edge.
// -----------------------------------------------------------------------------
module tb_trigger_sequencer;

  localparam int BAW = 6;
  localparam int BDW = 32;
  localparam int SDW = 32;
  localparam int SEW = 2;
  localparam int TSN = 4;
  localparam int TCW = 16;
  localparam int STW = 2;

  localparam logic [BDW-1:0] CFG_FINAL  = 32'h0002_0000;
  localparam logic [BDW-1:0] CFG_INVERT = 32'h0001_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           bus_wready;
  logic           bus_wvalid = 1'b0;
  logic [BAW-1:0] bus_waddr  = '0;
  logic [BDW-1:0] bus_wdata  = '0;
  logic           ctl_arm    = 1'b0;
  logic           ctl_abort  = 1'b0;
  logic [1:0]     sts_state;
  logic [STW-1:0] sts_stage;
  logic           sti_tready;
  logic           sti_tvalid = 1'b0;
  logic [SDW-1:0] sti_tdata  = '0;
  logic           sto_tready = 1'b1;
  logic           sto_tvalid;
  logic [SEW-1:0] sto_tevent;
  logic [SDW-1:0] sto_tdata;

  int vectors     = 0;
  int miscompares = 0;

  trigger_sequencer #(
    .BAW(BAW), .BDW(BDW), .SDW(SDW), .SEW(SEW), .TSN(TSN), .TCW(TCW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_wready (bus_wready),
    .bus_wvalid (bus_wvalid),
    .bus_waddr  (bus_waddr),
    .bus_wdata  (bus_wdata),
    .ctl_arm    (ctl_arm),
    .ctl_abort  (ctl_abort),
    .sts_state  (sts_state),
    .sts_stage  (sts_stage),
    .sti_tready (sti_tready),
    .sti_tvalid (sti_tvalid),
    .sti_tdata  (sti_tdata),
    .sto_tready (sto_tready),
    .sto_tvalid (sto_tvalid),
    .sto_tevent (sto_tevent),
    .sto_tdata  (sto_tdata)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [BAW-1:0] addr, input logic [BDW-1:0] data);
    bus_wvalid = 1'b1;
    bus_waddr  = addr;
    bus_wdata  = data;
    tick();
    bus_wvalid = 1'b0;
  endtask

  task automatic stage_cfg(input int stg, input logic [BDW-1:0] mask,
                           input logic [BDW-1:0] value, input logic [BDW-1:0] cfg);
    bus_write(BAW'(stg * 4 + 0), mask);
    bus_write(BAW'(stg * 4 + 1), value);
    bus_write(BAW'(stg * 4 + 2), cfg);
  endtask

  task automatic arm();
    ctl_arm = 1'b1;
    tick();
    ctl_arm = 1'b0;
  endtask

  task automatic abort();
    ctl_abort = 1'b1;
    tick();
    ctl_abort = 1'b0;
  endtask

  // One input transfer (caller keeps the output side ready).
  task automatic send(input logic [SDW-1:0] d);
    sti_tvalid = 1'b1;
    sti_tdata  = d;
    tick();
    sti_tvalid = 1'b0;
  endtask

  // Send a sample and check the tagged sample that comes out.
  task automatic send_chk(input string tag, input logic [SDW-1:0] d, input logic [1:0] ev);
    send(d);
    chk({tag, ".valid"}, 64'(sto_tvalid), 64'd1);
    chk({tag, ".data"},  64'(sto_tdata),  64'(d));
    chk({tag, ".event"}, 64'(sto_tevent), 64'(ev));
  endtask

  // Watchdog: the sequence below has no open-ended waits, this is a backstop.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst.tvalid", 64'(sto_tvalid), 64'd0);
    chk("rst.tevent", 64'(sto_tevent), 64'd0);
    chk("rst.tdata",  64'(sto_tdata),  64'd0);
    chk("rst.state",  64'(sts_state),  64'd0);
    chk("rst.stage",  64'(sts_stage),  64'd0);
    chk("rst.wready", 64'(bus_wready), 64'd1);
    chk("rst.tready", 64'(sti_tready), 64'd1);

    // T1: reset mid-stream clears stream, FSM and config
    stage_cfg(0, 32'hFF, 32'h5A, 32'h1);
    arm();
    chk("t1.armed", 64'(sts_state), 64'd1);
    send_chk("t1.adv", 32'h5A, 2'b10);
    chk("t1.stage1", 64'(sts_stage), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t1.tvalid", 64'(sto_tvalid), 64'd0);
    chk("t1.state",  64'(sts_state),  64'd0);
    chk("t1.stage",  64'(sts_stage),  64'd0);
    // Cleared stage 0 (mask 0, count 0, not final) advances on any sample.
    arm();
    send_chk("t1.cleared", 32'h00, 2'b10);
    chk("t1.cleared.stage", 64'(sts_stage), 64'd1);
    abort();
    chk("t1.abort", 64'(sts_state), 64'd0);

    // T2: single stage, plus ignored writes to reserved / out-of-range slots
    stage_cfg(0, 32'hFF, 32'h5A, CFG_FINAL | 32'h1);
    bus_write(6'h10, 32'h0);   // stage 4 mask: must not alias onto stage 0
    bus_write(6'h11, 32'h0);   // stage 4 value
    bus_write(6'h03, 32'hFFFF_FFFF); // reserved register
    send_chk("t2.idle", 32'h5A, 2'b00);
    chk("t2.idle.state", 64'(sts_state), 64'd0);
    arm();
    send_chk("t2.s00", 32'h00, 2'b00);
    chk("t2.s00.state", 64'(sts_state), 64'd1);
    send_chk("t2.s5a", 32'h5A, 2'b01);
    chk("t2.fired", 64'(sts_state), 64'd2);
    send_chk("t2.after", 32'h5A, 2'b00);
    chk("t2.hold", 64'(sts_state), 64'd2);

    // T4: backpressure holds the triggering sample without duplication
    arm();
    chk("t4.rearm", 64'(sts_state), 64'd1);
    send_chk("t4.s5a", 32'h5A, 2'b01);
    sto_tready = 1'b0;
    sti_tvalid = 1'b1;
    sti_tdata  = 32'h77;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t4.tready", 64'(sti_tready), 64'd0);
      chk("t4.tvalid", 64'(sto_tvalid), 64'd1);
      chk("t4.tdata",  64'(sto_tdata),  64'h5A);
      chk("t4.tevent", 64'(sto_tevent), 64'd1);
      tick();
    end
    sto_tready = 1'b1;
    tick();
    sti_tvalid = 1'b0;
    chk("t4.next.data",  64'(sto_tdata),  64'h77);
    chk("t4.next.event", 64'(sto_tevent), 64'd0);
    tick();
    chk("t4.drain", 64'(sto_tvalid), 64'd0);

    // T3: two-stage sequence, a miss clears the count
    stage_cfg(0, 32'hFF, 32'h11, 32'h2);
    stage_cfg(1, 32'hFF, 32'h22, CFG_FINAL);
    arm();
    send_chk("t3.s1", 32'h11, 2'b00);
    send_chk("t3.s2", 32'h33, 2'b00);
    send_chk("t3.s3", 32'h11, 2'b00);
    send_chk("t3.s4", 32'h11, 2'b10);
    chk("t3.stage", 64'(sts_stage), 64'd1);
    send_chk("t3.s5", 32'h22, 2'b01);
    chk("t3.fired", 64'(sts_state), 64'd2);

    // T5: inverted match with count 3
    stage_cfg(0, 32'h01, 32'h00, CFG_FINAL | CFG_INVERT | 32'h3);
    arm();
    send_chk("t5.s1", 32'h1, 2'b00);
    send_chk("t5.s2", 32'h1, 2'b00);
    send_chk("t5.s3", 32'h0, 2'b00);
    send_chk("t5.s4", 32'h1, 2'b00);
    send_chk("t5.s5", 32'h1, 2'b00);
    send_chk("t5.s6", 32'h1, 2'b01);
    chk("t5.fired", 64'(sts_state), 64'd2);

    // T6: control priority
    arm();
    chk("t6.arm.state", 64'(sts_state), 64'd1);
    chk("t6.arm.stage", 64'(sts_stage), 64'd0);
    ctl_arm   = 1'b1;
    ctl_abort = 1'b1;
    tick();
    ctl_arm   = 1'b0;
    ctl_abort = 1'b0;
    chk("t6.both", 64'(sts_state), 64'd0);

    // Satisfying hit coincident with arm is dropped and the count restarts.
    arm();
    send_chk("t6.c1", 32'h1, 2'b00);
    send_chk("t6.c2", 32'h1, 2'b00);
    ctl_arm = 1'b1;
    send_chk("t6.c3arm", 32'h1, 2'b00);
    ctl_arm = 1'b0;
    chk("t6.c3.state", 64'(sts_state), 64'd1);
    send_chk("t6.d1", 32'h1, 2'b00);
    send_chk("t6.d2", 32'h1, 2'b00);
    send_chk("t6.d3", 32'h1, 2'b01);
    chk("t6.fired", 64'(sts_state), 64'd2);

    // Arm from FIRED restarts at stage 0; abort from FIRED goes idle.
    arm();
    chk("t6.refire.state", 64'(sts_state), 64'd1);
    chk("t6.refire.stage", 64'(sts_stage), 64'd0);
    send_chk("t6.e1", 32'h1, 2'b00);
    send_chk("t6.e2", 32'h1, 2'b00);
    send_chk("t6.e3", 32'h1, 2'b01);
    abort();
    chk("t6.abort.state", 64'(sts_state), 64'd0);
    send_chk("t6.idle", 32'h1, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
